sync_fifo_param: RTL

//  Single-clock, parametrised FIFO: successor to the dual-clock FIFO for same-domain buffering.

---
 rtl/sync_fifo_param.sv | 109 ++++++++++
 1 files changed

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and selectable registered or first-word-fall-through read.
module sync_fifo_param #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned PTR_WIDTH  = $clog2(DEPTH),
  parameter int unsigned AF_THRESH  = DEPTH - 2,
  parameter int unsigned AE_THRESH  = 2,
  parameter bit          FWFT       = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [PTR_WIDTH:0]    count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned CW = PTR_WIDTH + 1;
  localparam logic [PTR_WIDTH:0] ONE     = CW'(1);
  localparam logic [PTR_WIDTH:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PTR_WIDTH:0] AF_C    = CW'(AF_THRESH);
  localparam logic [PTR_WIDTH:0] AE_C    = CW'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_WIDTH:0]    w_ptr_q, w_ptr_d;
  logic [PTR_WIDTH:0]    r_ptr_q, r_ptr_d;
  logic [PTR_WIDTH:0]    count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  w_acc, r_acc;

  // Status flags decode the registered occupancy
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  assign w_acc = w_en & ~full;
  assign r_acc = r_en & ~empty;

  // Storage is not cleared by reset; a reset cycle blocks the write
  always_ff @(posedge clk) begin
    if (!rst && w_acc) begin
      mem_q[w_ptr_q[PTR_WIDTH-1:0]] <= w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    count_d = count_q;
    ovf_d   = ovf_q | (w_en & full);
    udf_d   = udf_q | (r_en & empty);
    if (w_acc) w_ptr_d = w_ptr_q + ONE;
    if (r_acc) r_ptr_d = r_ptr_q + ONE;
    case ({w_acc, r_acc})
      2'b10:   count_d = count_q + ONE;
      2'b01:   count_d = count_q - ONE;
      default: count_d = count_q;
    endcase
  end

  if (FWFT == 1'b0) begin : g_reg_read
    logic [DATA_WIDTH-1:0] r_data_q, r_data_d;

    always_comb begin
      r_data_d = r_data_q;
      if (r_acc) r_data_d = mem_q[r_ptr_q[PTR_WIDTH-1:0]];
    end

    always_ff @(posedge clk) begin
      if (rst) r_data_q <= '0;
      else     r_data_q <= r_data_d;
    end

    assign r_data = r_data_q;
  end else begin : g_fwft
    // Head word presented directly; meaningless while empty
    assign r_data = mem_q[r_ptr_q[PTR_WIDTH-1:0]];
  end

endmodule
